addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values multiple of 4, 8..64.
REQ-002 SHALL have parameter NIB_PER_CYC, default 1, nibbles processed per cycle; WIDTH/4 divisible by NIB_PER_CYC.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: operand handshake.
REQ-006 SHALL have ports a, b  input  WIDTH  operands.
REQ-007 SHALL have ports cin input 1 (carry in, 6502 sense: 1 = no borrow on subtract), sub input 1 (1 = a - b), bcd input 1 (1 = packed-decimal mode).
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-009 SHALL have port sum  output  WIDTH  result.
REQ-010 SHALL have ports cout output 1, hcarry output WIDTH/4 (carry out of each nibble), ovf output 1, zero output 1.

Function
REQ-011 SHALL operate as FSM with states IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; in IDLE with in_valid=1, SHALL capture a, b, cin, sub, bcd and go to BUSY.
REQ-013 Operand changes after capture SHALL NOT affect the result.
REQ-014 BUSY SHALL process NIB_PER_CYC nibbles per cycle, least significant first, carry chained between nibbles and cycles; b inverted bitwise when sub=1.
REQ-015 BUSY SHALL last exactly WIDTH/(4*NIB_PER_CYC) cycles, then go to DONE; out_valid asserts on the cycle after the last BUSY cycle.
REQ-016 Binary mode: sum = a + (b XOR {WIDTH{sub}}) + cin mod 2^WIDTH; cout = carry out of MSB.
REQ-017 BCD add: per nibble, if raw nibble sum > 9 or nibble carry = 1, add 6 and force nibble carry = 1.
REQ-018 BCD subtract: per nibble, if nibble carry out = 0 (borrow), add 0xA mod 16 to the nibble; nibble carry unchanged.
REQ-019 hcarry[i] SHALL be the (decimal-adjusted in BCD mode) carry out of nibble i; cout SHALL equal hcarry[WIDTH/4-1].
REQ-020 ovf SHALL be the XOR of carries into and out of the MSB of the binary (unadjusted) sum, in both modes.
REQ-021 zero SHALL be 1 iff final sum == 0.
REQ-022 DONE SHALL hold out_valid=1 and all result outputs stable until out_ready=1; on that edge go to IDLE.
REQ-023 No back-to-back overlap: new operands accepted no earlier than cycle after the DONE handshake (in_ready=1 in IDLE only).
REQ-024 Non-BCD operand digits (>9) in BCD mode SHALL give deterministic results per REQ-017/018 with no error flag.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, hcarry=0, ovf=0, zero=0.
REQ-026 Reset in BUSY or DONE SHALL abandon the operation; no result is ever presented for it.
REQ-027 Reset release SHALL be synchronized externally; block needs first in_valid no earlier than first edge after release.

Structure
REQ-028 A shared package SHALL hold FSM state encoding and constants NIB=4, BCD_ADJ_ADD=6, BCD_ADJ_SUB=10.
REQ-029 SHALL instantiate one combinational sub-module nib_addsub_bcd (4-bit add with cin, bcd, sub, returning adjusted nibble, adjusted carry, raw MSB carry-in/out), NIB_PER_CYC copies chained.
REQ-030 Operands SHALL be held in shift registers shifted by 4*NIB_PER_CYC per BUSY cycle; cycle counter width clog2(WIDTH/4+1).

Verification
REQ-031 WIDTH=16, binary, a=0x7FFF, b=0x0001, cin=0, sub=0 -> after 4 BUSY cycles sum=0x8000, cout=0, ovf=1, zero=0, hcarry=0b0111.
REQ-032 WIDTH=16, binary sub, a=0x0005, b=0x0005, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0.
REQ-033 WIDTH=16, BCD add, a=0x0999, b=0x0001, cin=0 -> sum=0x1000, cout=0, hcarry=0b0111; BCD sub a=0x0000, b=0x0001, cin=1 -> sum=0x9999, cout=0.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; in_valid during that time ignored.
REQ-035 rst_n pulsed low during second BUSY cycle -> outputs go to reset values asynchronously, next transaction produces correct result.
REQ-036 NIB_PER_CYC=4, WIDTH=16 and WIDTH=64 random binary/BCD vectors vs. reference model -> match, latency 1 and 4 BUSY cycles respectively.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the nibble-serial binary/packed-decimal adder-subtractor.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIB = 4;
  localparam logic [NIB-1:0] BCD_ADJ_ADD = 4'd6;
  localparam logic [NIB-1:0] BCD_ADJ_SUB = 4'd10;

endpackage

// File: rtl/nib_addsub_bcd.sv
// One-nibble add/subtract slice with 6502-style decimal adjust.
module nib_addsub_bcd
  import addsub_seq_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  input  logic           sub,
  input  logic           bcd,
  output logic [NIB-1:0] sum,
  output logic           cout,
  output logic           msb_cin,
  output logic           msb_cout
);

  logic [NIB-1:0] b_eff;
  logic [NIB:0]   raw;

  always_comb begin
    b_eff    = b ^ {NIB{sub}};
    raw      = {1'b0, a} + {1'b0, b_eff} + {{NIB{1'b0}}, cin};
    msb_cin  = raw[NIB-1] ^ a[NIB-1] ^ b_eff[NIB-1];
    msb_cout = raw[NIB];
    sum      = raw[NIB-1:0];
    cout     = raw[NIB];
    // Decimal add forces a carry on correction; decimal subtract keeps the binary borrow.
    if (bcd && !sub) begin
      if (raw > (NIB+1)'(9)) begin
        sum  = raw[NIB-1:0] + BCD_ADJ_ADD;
        cout = 1'b1;
      end
    end else if (bcd && sub && !raw[NIB]) begin
      sum = raw[NIB-1:0] + BCD_ADJ_SUB;
    end
  end

endmodule

// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: operands consumed NIB_PER_CYC nibbles per cycle, LSB first.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for operands
// BUSY    | shifting operands through the nibble slices
// DONE    | result held with out_valid=1 until out_ready
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NIB_PER_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic               sub,
  input  logic               bcd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic [WIDTH/4-1:0] hcarry,
  output logic               ovf,
  output logic               zero
);

  localparam int NNIB  = WIDTH / NIB;
  localparam int STEP  = NIB * NIB_PER_CYC;
  localparam int NCYC  = NNIB / NIB_PER_CYC;
  localparam int CNT_W = $clog2(NNIB + 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh, b_sh, sum_sh, sum_nxt;
  logic [NNIB-1:0]        hc_sh, hc_nxt, ov_sh, ov_nxt;
  logic                   carry, sub_r, bcd_r, zero_r;
  logic [CNT_W-1:0]       cnt;
  logic                   capture, last_cyc;
  logic [NIB_PER_CYC:0]   chain;
  logic [STEP-1:0]        step_sum;
  logic [NIB_PER_CYC-1:0] step_ov;

  assign capture  = (state == ST_IDLE) && in_valid;
  assign last_cyc = (state == ST_BUSY) && (cnt == CNT_W'(1));
  assign chain[0] = carry;

  for (genvar i = 0; i < NIB_PER_CYC; i++) begin : g_nib
    logic mci, mco;
    nib_addsub_bcd u_nib (
      .a        (a_sh[i*NIB +: NIB]),
      .b        (b_sh[i*NIB +: NIB]),
      .cin      (chain[i]),
      .sub      (sub_r),
      .bcd      (bcd_r),
      .sum      (step_sum[i*NIB +: NIB]),
      .cout     (chain[i+1]),
      .msb_cin  (mci),
      .msb_cout (mco)
    );
    assign step_ov[i] = mci ^ mco;
  end

  // New nibbles enter at the top so the result is LSB-aligned after the last shift.
  always_comb begin
    sum_nxt                        = sum_sh >> STEP;
    sum_nxt[WIDTH-1 -: STEP]       = step_sum;
    hc_nxt                         = hc_sh >> NIB_PER_CYC;
    hc_nxt[NNIB-1 -: NIB_PER_CYC]  = chain[NIB_PER_CYC:1];
    ov_nxt                         = ov_sh >> NIB_PER_CYC;
    ov_nxt[NNIB-1 -: NIB_PER_CYC]  = step_ov;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_BUSY;
      ST_BUSY: if (last_cyc)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      hc_sh  <= '0;
      ov_sh  <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      bcd_r  <= 1'b0;
      zero_r <= 1'b0;
      cnt    <= '0;
    end else if (capture) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      sub_r <= sub;
      bcd_r <= bcd;
      cnt   <= CNT_W'(NCYC);
    end else if (state == ST_BUSY) begin
      a_sh   <= a_sh >> STEP;
      b_sh   <= b_sh >> STEP;
      carry  <= chain[NIB_PER_CYC];
      cnt    <= cnt - CNT_W'(1);
      sum_sh <= sum_nxt;
      hc_sh  <= hc_nxt;
      ov_sh  <= ov_nxt;
      if (last_cyc) zero_r <= (sum_nxt == '0);
    end
  end

  assign sum    = sum_sh;
  assign hcarry = hc_sh;
  assign cout   = hc_sh[NNIB-1];
  assign ovf    = ov_sh[NNIB-1];
  assign zero   = zero_r;

endmodule

// File: tb/tb_addsub_seq.sv
// Randomized bench for addsub_seq at three configurations against a nibble-arithmetic model.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [63:0] a_i [3];
  logic [63:0] b_i [3];
  logic        cin_i [3], sub_i [3], bcd_i [3], iv_i [3], ordy_i [3];

  logic [15:0] sum0, sum1;
  logic [63:0] sum2;
  logic [3:0]  hc0, hc1;
  logic [15:0] hc2;
  logic co0, co1, co2, ovf0, ovf1, ovf2, z0, z1, z2;
  logic ir0, ir1, ir2, ovl0, ovl1, ovl2;

  logic [63:0] o_sum [3];
  logic [15:0] o_hc [3];
  logic        o_co [3], o_ovf [3], o_z [3], o_ir [3], o_ov [3];

  assign o_sum[0] = {48'd0, sum0};
  assign o_sum[1] = {48'd0, sum1};
  assign o_sum[2] = sum2;
  assign o_hc[0]  = {12'd0, hc0};
  assign o_hc[1]  = {12'd0, hc1};
  assign o_hc[2]  = hc2;
  assign o_co[0] = co0;   assign o_co[1] = co1;   assign o_co[2] = co2;
  assign o_ovf[0] = ovf0; assign o_ovf[1] = ovf1; assign o_ovf[2] = ovf2;
  assign o_z[0] = z0;     assign o_z[1] = z1;     assign o_z[2] = z2;
  assign o_ir[0] = ir0;   assign o_ir[1] = ir1;   assign o_ir[2] = ir2;
  assign o_ov[0] = ovl0;  assign o_ov[1] = ovl1;  assign o_ov[2] = ovl2;

  addsub_seq #(.WIDTH(16), .NIB_PER_CYC(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_i[0]), .in_ready(ir0),
    .a(a_i[0][15:0]), .b(b_i[0][15:0]), .cin(cin_i[0]), .sub(sub_i[0]), .bcd(bcd_i[0]),
    .out_valid(ovl0), .out_ready(ordy_i[0]), .sum(sum0), .cout(co0), .hcarry(hc0),
    .ovf(ovf0), .zero(z0));

  addsub_seq #(.WIDTH(16), .NIB_PER_CYC(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_i[1]), .in_ready(ir1),
    .a(a_i[1][15:0]), .b(b_i[1][15:0]), .cin(cin_i[1]), .sub(sub_i[1]), .bcd(bcd_i[1]),
    .out_valid(ovl1), .out_ready(ordy_i[1]), .sum(sum1), .cout(co1), .hcarry(hc1),
    .ovf(ovf1), .zero(z1));

  addsub_seq #(.WIDTH(64), .NIB_PER_CYC(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_i[2]), .in_ready(ir2),
    .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .sub(sub_i[2]), .bcd(bcd_i[2]),
    .out_valid(ovl2), .out_ready(ordy_i[2]), .sum(sum2), .cout(co2), .hcarry(hc2),
    .ovf(ovf2), .zero(z2));

  logic [63:0] e_sum [3];
  logic [15:0] e_hc [3];
  logic        e_co [3], e_ovf [3], e_z [3];
  bit          e_valid [3];

  function automatic int wid(input int k);
    return (k == 2) ? 64 : 16;
  endfunction

  function automatic int ncyc(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  // Digit-by-digit arithmetic as a person would do it on paper.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub, input logic bcd,
                                output logic [63:0] s, output logic [15:0] hc,
                                output logic co, output logic ov, output logic z);
    int c, an, bn, r, c3;
    s = '0; hc = '0; ov = 1'b0; c = cin ? 1 : 0;
    for (int i = 0; i < w / 4; i++) begin
      an = int'(a[4*i +: 4]);
      bn = int'(b[4*i +: 4]);
      if (sub) bn = 15 - bn;
      r = an + bn + c;
      if (i == w / 4 - 1) begin
        c3 = ((an % 8) + (bn % 8) + c) / 8;
        ov = (c3 != r / 16);
      end
      if (bcd && !sub) begin
        if (r > 9) begin r = (r + 6) % 16; c = 1; end
        else c = 0;
      end else if (bcd) begin
        c = r / 16; r = r % 16;
        if (c == 0) r = (r + 10) % 16;
      end else begin
        c = r / 16; r = r % 16;
      end
      s[4*i +: 4] = 4'(r);
      hc[i] = (c != 0);
    end
    co = hc[w/4-1];
    z  = (s == 64'd0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk("reset_sum", o_sum[k], 64'd0);
        chk("reset_flags", 64'({o_hc[k], o_co[k], o_ovf[k], o_z[k], o_ov[k], o_ir[k]}), 64'd1);
      end else if (o_ov[k]) begin
        chk("spurious_valid", 64'(o_ov[k] & ~e_valid[k]), 64'd0);
        if (e_valid[k]) begin
          chk("sum", o_sum[k], e_sum[k]);
          chk("hcarry", 64'(o_hc[k]), 64'(e_hc[k]));
          chk("cout_ovf_zero", 64'({o_co[k], o_ovf[k], o_z[k]}), 64'({e_co[k], e_ovf[k], e_z[k]}));
        end
      end
    end
  end

  function automatic logic [63:0] rand_digits();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic run_txn(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic bcd,
                         input int hold, input bit poke);
    logic [63:0] ms; logic [15:0] mh; logic mc, mo, mz;
    int lat, wn;
    model(wid(k), a, b, cin, sub, bcd, ms, mh, mc, mo, mz);
    @(negedge clk);
    wn = 0;
    while (!o_ir[k] && wn < 50) begin @(negedge clk); wn++; end
    chk("in_ready_idle", 64'(o_ir[k]), 64'd1);
    a_i[k] = a; b_i[k] = b; cin_i[k] = cin; sub_i[k] = sub; bcd_i[k] = bcd; iv_i[k] = 1'b1;
    @(posedge clk); #1;
    iv_i[k] = 1'b0;
    a_i[k] = {$urandom, $urandom}; b_i[k] = {$urandom, $urandom};
    cin_i[k] = 1'($urandom); sub_i[k] = 1'($urandom); bcd_i[k] = 1'($urandom);
    e_sum[k] = ms; e_hc[k] = mh; e_co[k] = mc; e_ovf[k] = mo; e_z[k] = mz; e_valid[k] = 1'b1;
    lat = 0;
    while (!o_ov[k] && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(ncyc(k)));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin iv_i[k] = 1'b1; a_i[k] = {$urandom, $urandom}; end
      chk("in_ready_done", 64'(o_ir[k]), 64'd0);
    end
    @(negedge clk);
    iv_i[k] = 1'b0; ordy_i[k] = 1'b1;
    @(posedge clk); #1;
    ordy_i[k] = 1'b0; e_valid[k] = 1'b0;
    chk("valid_drop", 64'(o_ov[k]), 64'd0);
    chk("in_ready_back", 64'(o_ir[k]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] ms; logic [15:0] mh; logic mc, mo, mz;
    for (int k = 0; k < 3; k++) begin
      a_i[k] = '0; b_i[k] = '0; cin_i[k] = 0; sub_i[k] = 0; bcd_i[k] = 0;
      iv_i[k] = 0; ordy_i[k] = 0; e_valid[k] = 0;
      e_sum[k] = '0; e_hc[k] = '0; e_co[k] = 0; e_ovf[k] = 0; e_z[k] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed anchors for the model.
    model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b0, ms, mh, mc, mo, mz);
    chk("pin_ovf_sum", ms, 64'h8000);
    chk("pin_ovf_flags", 64'({mh, mc, mo, mz}), 64'({16'h0007, 1'b0, 1'b1, 1'b0}));
    model(16, 64'h0005, 64'h0005, 1'b1, 1'b1, 1'b0, ms, mh, mc, mo, mz);
    chk("pin_sub_sum", ms, 64'h0000);
    chk("pin_sub_flags", 64'({mc, mo, mz}), 64'({1'b1, 1'b0, 1'b1}));
    model(16, 64'h0999, 64'h0001, 1'b0, 1'b0, 1'b1, ms, mh, mc, mo, mz);
    chk("pin_bcd_add", 64'({ms[15:0], mh, mc}), 64'({16'h1000, 16'h0007, 1'b0}));
    model(16, 64'h0000, 64'h0001, 1'b1, 1'b1, 1'b1, ms, mh, mc, mo, mz);
    chk("pin_bcd_sub", 64'({ms[15:0], mc}), 64'({16'h9999, 1'b0}));

    for (int k = 0; k < 2; k++) begin
      run_txn(k, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_txn(k, 64'h0005, 64'h0005, 1'b1, 1'b1, 1'b0, 1, 1'b0);
      run_txn(k, 64'h0999, 64'h0001, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_txn(k, 64'h0000, 64'h0001, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    end

    // Long stall in DONE with operands offered meanwhile.
    run_txn(0, 64'h1234, 64'h4321, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    run_txn(0, 64'h5678, 64'h1111, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Abort in the second BUSY cycle.
    @(negedge clk);
    a_i[0] = 64'h1234; b_i[0] = 64'h1111; cin_i[0] = 0; sub_i[0] = 0; bcd_i[0] = 0; iv_i[0] = 1'b1;
    @(posedge clk); #1;
    iv_i[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", 64'(o_ir[0]), 64'd1);
    chk("async_out_valid", 64'(o_ov[0]), 64'd0);
    chk("async_sum", o_sum[0], 64'd0);
    chk("async_flags", 64'({o_hc[0], o_co[0], o_ovf[0], o_z[0]}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_txn(0, 64'h0999, 64'h0999, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [63:0] ra, rb;
        logic rbcd;
        rbcd = 1'($urandom);
        if (rbcd && ($urandom_range(0, 3) != 0)) begin
          ra = rand_digits(); rb = rand_digits();
        end else begin
          ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        end
        run_txn(k, ra, rb, 1'($urandom), 1'($urandom), rbcd,
                int'($urandom_range(0, 2)), bit'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
